// File: rtl/alu_mul_seq.sv
// Shift-and-add 8x8 multiply sequencer (low 8 bits) driving the shared 8-bit ALU.
// Optional feature: define ALU_MUL_SEQ_EARLY_EXIT_EN to stop once the remaining multiplier bits are zero.
module alu_mul_seq #(
   parameter int unsigned ITERATIONS = 8
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_result,
   output logic [7:0] o_aluA,
   output logic [7:0] o_aluB,
   output logic [1:0] o_aluOp,
   output logic       o_aluSub,
   output logic       o_aluShiftLeft,
   output logic       o_aluOe,
   input  logic [7:0] i_aluY,
   input  logic       i_aluZero
);

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 3;
   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SHIFT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADD,
      ST_SHL,
      ST_SHR,
      ST_DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    acc;
   logic [W-1:0]    mcand;
   logic [W-1:0]    mplier;
   logic [CW-1:0]   count;
   logic            early_start;
   logic            early_shr;
   logic            last_iter;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
   assign early_start = (i_b == '0);
   assign early_shr   = i_aluZero;
`else
   logic unused_alu_zero;
   assign unused_alu_zero = i_aluZero;
   assign early_start     = 1'b0;
   assign early_shr       = 1'b0;
`endif

   assign last_iter = (count == CW'(ITERATIONS - 1));

   // Next-state selection
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               if (early_start)  state_nxt = ST_DONE;
               else if (i_b[0])  state_nxt = ST_ADD;
               else              state_nxt = ST_SHL;
            end
         end
         ST_ADD:  state_nxt = ST_SHL;
         ST_SHL:  state_nxt = ST_SHR;
         ST_SHR: begin
            if (last_iter || early_shr) state_nxt = ST_DONE;
            else if (i_aluY[0])         state_nxt = ST_ADD;
            else                        state_nxt = ST_SHL;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ALU drive is a pure function of state and the working registers
   always_comb begin
      o_aluA         = '0;
      o_aluB         = '0;
      o_aluOp        = OP_ADD;
      o_aluSub       = 1'b0;
      o_aluShiftLeft = 1'b0;
      o_aluOe        = 1'b0;
      case (state)
         ST_ADD: begin
            o_aluOp = OP_ADD;
            o_aluA  = acc;
            o_aluB  = mcand;
            o_aluOe = 1'b1;
         end
         ST_SHL: begin
            o_aluOp        = OP_SHIFT;
            o_aluShiftLeft = 1'b1;
            o_aluA         = mcand;
            o_aluB         = W'(1);
            o_aluOe        = 1'b1;
         end
         ST_SHR: begin
            o_aluOp = OP_SHIFT;
            o_aluA  = mplier;
            o_aluB  = W'(1);
            o_aluOe = 1'b1;
         end
         default: ;
      endcase
   end

   // Working registers, handshake and result; the product is published on entry to DONE
   // so it is already valid while o_done is high.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= ST_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         count    <= '0;
         o_result <= '0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         o_busy <= (state_nxt != ST_IDLE);
         o_done <= (state_nxt == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  acc    <= '0;
                  mcand  <= i_a;
                  mplier <= i_b;
                  count  <= '0;
                  if (early_start) o_result <= '0;
               end
            end
            ST_ADD: acc <= i_aluY;
            ST_SHL: mcand <= i_aluY;
            ST_SHR: begin
               mplier <= i_aluY;
               count  <= count + CW'(1);
               if (state_nxt == ST_DONE) o_result <= acc;
            end
            default: ;
         endcase
      end
   end

endmodule
